image_link_scheduler: RTL

Frame-level sequencer for the FPGA-to-Nano UART image link. Sits between the camera capture path and the image sender: it decides when a frame is sent, freezes the frame buffer at a clean frame boundary while pixels stream out, holds the sender in reset between frames, and enforces an inter-frame gap so the Nano can resynchronise.

---
 rtl/image_link_scheduler.sv | 135 +++++++++++++
 1 files changed

// File: rtl/image_link_scheduler.sv
// image_link_scheduler: frame-level sequencer for the FPGA-to-Nano UART image link.
// Waits for a clean camera frame boundary, freezes the frame buffer while the
// image sender streams pixels, then holds the sender in reset for an inter-frame gap.
// Optional feature macro: SEND_TIMEOUT_EN adds a watchdog on the SENDING state.
module image_link_scheduler #(
    parameter int unsigned FRAME_GAP_CYCLES = 500_000,
    parameter int unsigned TIMEOUT_CYCLES   = 400_000_000,
    parameter int unsigned CNT_W            = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             send_req,
    input  logic             continuous,
    input  logic             abort,
    input  logic             vsync,
    input  logic             sender_done,
    output logic             sender_rst,
    output logic             fb_write_en,
    output logic             busy,
    output logic [CNT_W-1:0] frame_count,
    output logic             timeout_err
);

    typedef enum logic [1:0] {StIdle, StWaitVsync, StSending, StGap} state_e;

    state_e      state_q;
    state_e      state_d;
    logic        vsync_q;
    logic [31:0] gap_cnt;
    logic [1:0]  guard_cnt;
    logic        done_ok;
`ifdef SEND_TIMEOUT_EN
    logic [31:0] wd_cnt;
    logic        timeout_hit;
`endif

    // Next-state selection; abort overrides every other transition.
    always_comb begin
        state_d = state_q;
        done_ok = 1'b0;
`ifdef SEND_TIMEOUT_EN
        timeout_hit = 1'b0;
`endif
        if (abort) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    if (send_req || continuous) state_d = StWaitVsync;
                end
                StWaitVsync: begin
                    // Only a fresh rising edge counts, not a level already high.
                    if (vsync && !vsync_q) state_d = StSending;
                end
                StSending: begin
                    // First two SENDING cycles ignore a stale done from the last frame.
                    if (sender_done && (guard_cnt == 2'd2)) begin
                        state_d = StGap;
                        done_ok = 1'b1;
                    end
`ifdef SEND_TIMEOUT_EN
                    else if (wd_cnt == TIMEOUT_CYCLES - 1) begin
                        state_d     = StGap;
                        timeout_hit = 1'b1;
                    end
`endif
                end
                StGap: begin
                    if (gap_cnt == '0) begin
                        state_d = (continuous || send_req) ? StWaitVsync : StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // State, registered Moore outputs and frame/gap/guard counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            vsync_q     <= 1'b0;
            sender_rst  <= 1'b1;
            fb_write_en <= 1'b1;
            busy        <= 1'b0;
            frame_count <= '0;
            gap_cnt     <= '0;
            guard_cnt   <= '0;
`ifdef SEND_TIMEOUT_EN
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            vsync_q     <= vsync;
            sender_rst  <= (state_d != StSending);
            fb_write_en <= (state_d != StSending);
            busy        <= (state_d != StIdle);

            if (done_ok) frame_count <= frame_count + 1'b1;

            if (abort) begin
                gap_cnt   <= '0;
                guard_cnt <= '0;
            end else begin
                if (state_q != StGap && state_d == StGap) begin
                    gap_cnt <= FRAME_GAP_CYCLES - 1;
                end else if (state_q == StGap && gap_cnt != '0) begin
                    gap_cnt <= gap_cnt - 1;
                end

                // Guard counter restarts at 0 on every SENDING entry.
                if (state_q != StSending) begin
                    guard_cnt <= '0;
                end else if (guard_cnt != 2'd2) begin
                    guard_cnt <= guard_cnt + 2'd1;
                end
            end

`ifdef SEND_TIMEOUT_EN
            if (abort || state_q != StSending) begin
                wd_cnt <= '0;
            end else begin
                wd_cnt <= wd_cnt + 32'd1;
            end
            if (timeout_hit) timeout_err <= 1'b1;
`endif
        end
    end

`ifndef SEND_TIMEOUT_EN
    assign timeout_err = 1'b0;
`endif

endmodule
